// File: rtl/axis_tx_packer.sv
// Packs an 8-bit byte stream into big-endian 32-bit AXI-Stream words and ends
// frames on input tlast, on a maximum word count, or after an idle timeout.
module axis_tx_packer #(
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 1000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] frame_cnt
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(MAX_WORDS - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);

  logic [31:0]    r_acc_data;
  logic [2:0]     r_acc_cnt;
  logic           r_acc_last;
  logic [WCW-1:0] r_word_cnt;
  logic [TW-1:0]  r_timer;

  logic        w_frame_open;
  logic        w_tmo_flush;
  logic        w_emit_req;
  logic        w_slot_free;
  logic        w_xfer;
  logic        w_out_last;
  logic        w_accept;
  logic [31:0] w_acc_data_nxt;
  logic [2:0]  w_acc_cnt_nxt;
  logic        w_acc_last_nxt;

  function automatic logic [31:0] keep_bytes(input logic [31:0] data, input logic [2:0] cnt);
    logic [31:0] mask;
    case (cnt)
      3'd0:    mask = 32'h0000_0000;
      3'd1:    mask = 32'hFF00_0000;
      3'd2:    mask = 32'hFFFF_0000;
      3'd3:    mask = 32'hFFFF_FF00;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return data & mask;
  endfunction

  assign w_frame_open = (r_word_cnt != '0) || (r_acc_cnt != 3'd0);
  // The timer parks on its last value until the flushing word (always tlast)
  // leaves, so the flush condition needs no separate state.
  assign w_tmo_flush  = w_frame_open && (r_timer == TMO_LAST);
  assign w_emit_req   = (r_acc_cnt == 3'd4) || r_acc_last || w_tmo_flush;
  assign w_slot_free  = !m_axis_tvalid || m_axis_tready;
  assign w_xfer       = w_emit_req && w_slot_free;
  assign w_out_last   = r_acc_last || w_tmo_flush || (r_word_cnt == WORD_LAST);
  assign s_axis_tready = ((r_acc_cnt < 3'd4) && !r_acc_last && !w_tmo_flush) || w_xfer;
  assign w_accept     = s_axis_tvalid && s_axis_tready;

  // Next accumulator: drain on xfer, then drop an accepted byte into the next lane.
  always_comb begin
    w_acc_data_nxt = r_acc_data;
    w_acc_cnt_nxt  = r_acc_cnt;
    w_acc_last_nxt = r_acc_last;
    if (w_xfer) begin
      w_acc_data_nxt = 32'h0000_0000;
      w_acc_cnt_nxt  = 3'd0;
      w_acc_last_nxt = 1'b0;
    end else begin
      w_acc_data_nxt = r_acc_data;
    end
    if (w_accept) begin
      case (w_acc_cnt_nxt)
        3'd0:    w_acc_data_nxt[31:24] = s_axis_tdata;
        3'd1:    w_acc_data_nxt[23:16] = s_axis_tdata;
        3'd2:    w_acc_data_nxt[15:8]  = s_axis_tdata;
        3'd3:    w_acc_data_nxt[7:0]   = s_axis_tdata;
        default: w_acc_data_nxt        = w_acc_data_nxt;
      endcase
      w_acc_cnt_nxt  = w_acc_cnt_nxt + 3'd1;
      w_acc_last_nxt = w_acc_last_nxt || s_axis_tlast;
    end else begin
      w_acc_cnt_nxt = w_acc_cnt_nxt;
    end
  end

  // Accumulator, output slot, frame bookkeeping and idle timer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_acc_data    <= 32'h0000_0000;
      r_acc_cnt     <= 3'd0;
      r_acc_last    <= 1'b0;
      r_word_cnt    <= '0;
      r_timer       <= '0;
      m_axis_tdata  <= 32'h0000_0000;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_cnt     <= 16'd0;
    end else begin
      r_acc_data <= w_acc_data_nxt;
      r_acc_cnt  <= w_acc_cnt_nxt;
      r_acc_last <= w_acc_last_nxt;

      if (w_xfer) begin
        m_axis_tdata  <= keep_bytes(r_acc_data, r_acc_cnt);
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= w_out_last;
        r_word_cnt    <= w_out_last ? '0 : r_word_cnt + 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (w_accept || (w_xfer && w_out_last)) begin
        r_timer <= '0;
      end else if (w_frame_open && !w_tmo_flush) begin
        r_timer <= r_timer + 1'b1;
      end

      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_tx_packer.sv
// Directed bench for axis_tx_packer with MAX_WORDS=4 and TIMEOUT=16.
module tb_axis_tx_packer;

  logic        aclk;
  logic        areset;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_acc_cyc = 0;
  int unsigned last_word_cyc = 0;
  logic [32:0] q[$];
  int unsigned q_cyc[$];

  axis_tx_packer #(.MAX_WORDS(4), .TIMEOUT(16)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .frame_cnt     (frame_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Capture every output handshake; inputs only change just after posedge.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      q.push_back({m_axis_tlast, m_axis_tdata});
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    logic took;
    took = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int g = 0; g < 64 && !took; g++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        took = 1'b1;
        last_acc_cyc = cyc;
      end
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("byte_accept", 33'(took), 33'd1);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic l);
    logic [32:0] got;
    if (q.size() != 0) begin
      got = q.pop_front();
      last_word_cyc = q_cyc.pop_front();
    end else begin
      got = 33'bx;
      last_word_cyc = 0;
    end
    check(tag, got, {l, d});
  endtask

  initial begin
    areset        = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    wait_cycles(3);
    check("rst_tvalid", 33'(m_axis_tvalid), 33'd0);
    check("rst_tlast",  33'(m_axis_tlast),  33'd0);
    check("rst_tdata",  33'(m_axis_tdata),  33'd0);
    check("rst_fcnt",   33'(frame_cnt),     33'd0);
    check("rst_sready", 33'(s_axis_tready), 33'd1);
    areset = 1'b0;
    wait_cycles(2);

    // Full-word frame
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), i == 7);
    wait_cycles(6);
    expect_word("full_w0", 32'h01020304, 1'b0);
    expect_word("full_w1", 32'h05060708, 1'b1);
    check("full_q",    33'(q.size()),  33'd0);
    check("full_fcnt", 33'(frame_cnt), 33'd1);

    // Partial last word
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i), i == 5);
    wait_cycles(6);
    expect_word("part_w0", 32'h11121314, 1'b0);
    expect_word("part_w1", 32'h15160000, 1'b1);
    check("part_q",    33'(q.size()),  33'd0);
    check("part_fcnt", 33'(frame_cnt), 33'd2);

    // Max-length split followed by timeout pad word
    for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i), 1'b0);
    wait_cycles(30);
    expect_word("max_w0", 32'h40414243, 1'b0);
    expect_word("max_w1", 32'h44454647, 1'b0);
    expect_word("max_w2", 32'h48494A4B, 1'b0);
    expect_word("max_w3", 32'h4C4D4E4F, 1'b1);
    expect_word("max_w4", 32'h50515253, 1'b0);
    expect_word("max_pad", 32'h00000000, 1'b1);
    check("max_pad_lat", 33'(last_word_cyc - last_acc_cyc), 33'd17);
    check("max_q",    33'(q.size()),  33'd0);
    check("max_fcnt", 33'(frame_cnt), 33'd4);

    // Timeout flush of a partial word
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    wait_cycles(10);
    check("tmo_early", 33'(q.size()), 33'd0);
    wait_cycles(15);
    expect_word("tmo_w0", 32'hAABBCC00, 1'b1);
    check("tmo_lat",  33'(last_word_cyc - last_acc_cyc), 33'd17);
    check("tmo_fcnt", 33'(frame_cnt), 33'd5);

    // Backpressure: 12 bytes with the output blocked for 10 cycles
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h61 + i), 1'b0);
    s_axis_tdata  = 8'h69;
    s_axis_tvalid = 1'b1;
    #1;
    check("bp_sready0", 33'(s_axis_tready), 33'd0);
    check("bp_hold0",   {m_axis_tlast, m_axis_tdata}, {1'b0, 32'h61626364});
    wait_cycles(2);
    check("bp_sready1", 33'(s_axis_tready), 33'd0);
    check("bp_hold1",   {m_axis_tlast, m_axis_tdata}, {1'b0, 32'h61626364});
    check("bp_valid",   33'(m_axis_tvalid), 33'd1);
    check("bp_none",    33'(q.size()),      33'd0);
    m_axis_tready = 1'b1;
    for (int i = 8; i < 12; i++) send_byte(8'(8'h61 + i), i == 11);
    wait_cycles(8);
    expect_word("bp_w0", 32'h61626364, 1'b0);
    expect_word("bp_w1", 32'h65666768, 1'b0);
    expect_word("bp_w2", 32'h696A6B6C, 1'b1);
    check("bp_q",    33'(q.size()),  33'd0);
    check("bp_fcnt", 33'(frame_cnt), 33'd6);

    // Reset in the middle of a frame with a held output word
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h71 + i), 1'b0);
    check("mrst_pre_valid", 33'(m_axis_tvalid), 33'd1);
    areset = 1'b1;
    wait_cycles(1);
    check("mrst_tvalid", 33'(m_axis_tvalid), 33'd0);
    check("mrst_fcnt",   33'(frame_cnt),     33'd0);
    check("mrst_sready", 33'(s_axis_tready), 33'd1);
    areset = 1'b0;
    m_axis_tready = 1'b1;
    wait_cycles(1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), i == 3);
    wait_cycles(8);
    expect_word("mrst_w0", 32'h21222324, 1'b1);
    check("mrst_q",    33'(q.size()),  33'd0);
    check("mrst_fcnt", 33'(frame_cnt), 33'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_tx_packer.md
# axis_tx_packer

Byte-to-word framing stage that sits directly upstream of the Ethernet transmit path's 32-bit AXI-Stream payload input, in the user clock domain. It packs an 8-bit application byte stream into big-endian 32-bit words and decides where frames end. A frame ends on an explicit input `tlast`, on a maximum-length limit, or on an idle timeout. Each output frame becomes one UDP datagram downstream.

## Interface
- `MAX_WORDS`, 256: maximum words per output frame (1..367); word counter width is `$clog2(MAX_WORDS+1)`.
- `TIMEOUT`, 1000: idle cycles before an open frame is force-closed (>=1).
- `aclk` in 1: single clock.
- `areset` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 8: input byte.
- `s_axis_tvalid` in 1: input byte valid.
- `s_axis_tlast` in 1: close the frame after this byte.
- `s_axis_tready` out 1: byte accepted when high with tvalid.
- `m_axis_tdata` out 32: packed word, first byte in [31:24].
- `m_axis_tvalid` out 1: word valid.
- `m_axis_tlast` out 1: last word of frame.
- `m_axis_tready` in 1: downstream accepts word.
- `frame_cnt` out 16: count of frames emitted (tlast handshakes), wraps at 0xFFFF→0.

## Operation
- **Accumulator.** `acc_data[31:0]` and `acc_cnt` (0..4) hold the accumulated bytes, plus the `acc_last` flag.
  - The byte accepted with `acc_cnt=k` is written to bits [31-8k:24-8k].
  - An input tlast sets `acc_last`.
- **Output register.** `m_axis_*` are registered; one word slot.
  - The slot is free when `!m_axis_tvalid || m_axis_tready`.
- **emit_req.** Asserted when any of the following holds:
  - `acc_cnt==4`;
  - `acc_last`;
  - `tmo_flush && acc_cnt>0`;
  - `tmo_flush && acc_cnt==0 && frame_open`.
- **xfer.** `xfer = emit_req && slot free`. On xfer:
  - `m_axis_tdata` gets `acc_data` with unfilled low bytes forced to 0x00.
  - `m_axis_tvalid` is set to 1.
  - `m_axis_tlast` is set to `acc_last || tmo_flush || word_cnt==MAX_WORDS-1`.
  - The accumulator clears.
- **Pad word.** A timeout with an empty accumulator and an open frame emits an all-zero word with tlast=1. This is the only case in which a pad word is produced.
- **s_axis_tready** = `(acc_cnt<4 && !acc_last && !tmo_flush) || xfer`.
  - This is combinational from `m_axis_tready`.
  - A byte accepted in an xfer cycle starts the new accumulator with `acc_cnt=1`.
- **word_cnt and frame_open.**
  - `word_cnt` increments on each xfer and clears on an xfer with tlast.
  - `frame_open = word_cnt>0 || acc_cnt>0`.
- **Timer.**
  - Counts while `frame_open` and no byte is accepted.
  - Clears on byte accept or on an xfer with tlast.
  - Reaching TIMEOUT sets `tmo_flush`, which holds until the xfer completes.
- **frame_cnt** increments on `m_axis_tvalid && m_axis_tready && m_axis_tlast`.

## Timing
- **Reset values.** On reset, all of the following are 0: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `frame_cnt`, `acc_cnt`, `acc_last`, `word_cnt`, timer, `tmo_flush`. `s_axis_tready` resets to 1.
- **Latency.** A completing byte (4th byte or tlast) accepted in cycle N gives `m_axis_tvalid` in N+2 if the slot is free in N+1.
  - Steady-state throughput with `m_axis_tready=1` is 4 bytes per 4 cycles; no bubble.
- **Output hold.** While `m_axis_tvalid && !m_axis_tready`, `m_axis_tdata` and `m_axis_tlast` are stable.
- **Backpressure.** With the accumulator full and the slot blocked, `s_axis_tready=0`; no byte is dropped.
- **Timeout timing.** The timer reaches TIMEOUT exactly TIMEOUT cycles after the last accepted byte; the word appears on the following cycle if the slot is free.
- **Simultaneous events.** Input tlast arriving on the byte that reaches `MAX_WORDS` gives a single tlast, not an extra word.
- **Mid-operation reset.** Reset during a frame discards the partial word, the held output word and the frame count. `m_axis_tvalid` is 0 in the cycle after reset is sampled.

## Test plan
- **Full-word frame.** Bytes 0x01..0x08, tlast on 0x08, `m_axis_tready=1` → words 0x01020304 (tlast=0), 0x05060708 (tlast=1); `frame_cnt=1`.
- **Partial last word.** Bytes 0x11..0x16, tlast on 0x16 → words 0x11121314, 0x15160000 (tlast=1).
- **Max-length split.** `MAX_WORDS=4`, 20 bytes back-to-back, no tlast, then idle → expected response:
  - word 4 has tlast=1;
  - word 5 is complete with tlast=0;
  - after TIMEOUT an all-zero word with tlast=1 is emitted;
  - `frame_cnt=2`.
- **Timeout flush.** Bytes 0xAA, 0xBB, 0xCC, then idle, `TIMEOUT=16` → 0xAABBCC00 with tlast=1, valid 17 cycles after 0xCC is accepted.
- **Backpressure.** Stream 12 bytes with `m_axis_tready=0` for 10 cycles → `s_axis_tready` drops after 8 bytes; the held word stays stable; all 12 bytes come out in order with no loss or duplication.
- **Reset mid-frame.** Assert `areset` after 5 bytes → `m_axis_tvalid=0`, `frame_cnt=0`; the next frame 0x21..0x24 with tlast → single word 0x21222324 with tlast=1.
